// File: rtl/overlay_pkg.sv
// -----------------------------------------------------------------------------
// overlay_pkg
//   Constants and types shared by the text/digit overlays: glyph geometry,
//   RGB444 colours, the blank font code, font ROM depth/address width,
//   the stage-1 pipeline record and the ROM address packing helper.
// -----------------------------------------------------------------------------
package overlay_pkg;

  // Unscaled glyph cell.
  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  // Font ROM: 16 codes x 16 rows, one byte per row.
  localparam int ROM_DEPTH = 256;
  localparam int ROM_AW    = $clog2(ROM_DEPTH);

  // Code that always reads back as an all-zero glyph.
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;

  // RGB444 colours.
  localparam logic [11:0] RGB_BLACK = 12'h000;
  localparam logic [11:0] RGB_CYAN  = 12'h0FF;

  // Stage-1 record travelling alongside the synchronous ROM read.
  typedef struct packed {
    logic       hit;    // pixel inside some digit cell
    logic       blank;  // render this cell empty (bad digit or cursor off)
    logic [2:0] col;    // glyph column, 0 = leftmost
  } stage1_t;

  // ROM address layout: {code, row}.
  function automatic logic [ROM_AW-1:0] rom_addr(input logic [3:0] code,
                                                 input logic [3:0] row);
    return {code, row};
  endfunction

endpackage

// File: rtl/digit_font_rom.sv
// -----------------------------------------------------------------------------
// digit_font_rom
//   Synchronous 8x16 font ROM for the decimal digits 0-9, one-cycle read.
//   Codes 10-15 read as all-zero rows. Bit 7 of a row is the leftmost pixel.
//   The data register clears asynchronously while reset is low.
//
// Ports
//   clk    in   pixel clock
//   reset  in   asynchronous active-low reset
//   addr   in   {code[3:0], row[3:0]}
//   data   out  glyph row, valid one clock after addr
// -----------------------------------------------------------------------------
module digit_font_rom
  import overlay_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW-1:0] addr,
  output logic [7:0]        data
);

  // Each glyph is stored as 16 bytes, row 0 in the most significant byte.
  function automatic logic [7:0] glyph_row(input logic [3:0] code,
                                           input logic [3:0] row);
    logic [127:0] g;
    case (code)
      4'd0:    g = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
      4'd1:    g = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
      4'd2:    g = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
      4'd3:    g = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
      4'd4:    g = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
      4'd5:    g = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
      4'd6:    g = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
      4'd7:    g = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
      4'd8:    g = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
      4'd9:    g = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
      default: g = '0;
    endcase
    return g[8*(15 - int'(row)) +: 8];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data <= 8'h00;
    end else begin
      data <= glyph_row(addr[7:4], addr[3:0]);
    end
  end

endmodule

// File: rtl/vga_digit_overlay.sv
// -----------------------------------------------------------------------------
// vga_digit_overlay
//   Renders NUM_FIELDS two-digit BCD fields (e.g. HH:MM:SS) as scaled 8x16
//   glyphs. Field k's tens digit starts at X0 + k*FIELD_PITCH, its units digit
//   follows immediately; all digits share the rows [Y0, Y0 + 16<<SCALE_LOG2).
//
//   Stream protocol: no handshake. One pixel coordinate is accepted on every
//   clock and its colour appears exactly two clocks later; video_on and
//   okmaquina travel down the pipe with the coordinate.
//
//   Compile-time option: define VGA_DIGIT_OVERLAY_BLINK_EN to build the
//   frame counter, blink phase and edit cursor. Without it cursor_sel and
//   frame_tick are ignored and every field is always visible.
//
// Ports
//   clk         in   pixel clock
//   reset       in   asynchronous active-low reset
//   okmaquina   in   overlay enable; low forces outputs to 0
//   video_on    in   active-video flag aligned with pix_x/pix_y
//   pix_x       in   [9:0] current column
//   pix_y       in   [9:0] current row
//   timer_in    in   [8*NUM_FIELDS-1:0] field k = [8k+7:8k], tens in high nibble
//   cursor_sel  in   0 = no cursor, k = field k-1 blinks
//   frame_tick  in   one-cycle pulse per frame
//   rgbtext     out  [11:0] RGB444 overlay colour
//   text_hit    out  pixel lies in any digit cell
// -----------------------------------------------------------------------------
module vga_digit_overlay
  import overlay_pkg::*;
#(
  parameter int          NUM_FIELDS  = 3,
  parameter int          X0          = 192,
  parameter int          Y0          = 320,
  parameter int          FIELD_PITCH = 128,
  parameter int          SCALE_LOG2  = 2,
  parameter logic [11:0] COLOR       = RGB_CYAN,
  parameter int          BLINK_LOG2  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              okmaquina,
  input  logic                              video_on,
  input  logic [9:0]                        pix_x,
  input  logic [9:0]                        pix_y,
  input  logic [8*NUM_FIELDS-1:0]           timer_in,
  input  logic [$clog2(NUM_FIELDS+1)-1:0]   cursor_sel,
  input  logic                              frame_tick,
  output logic [11:0]                       rgbtext,
  output logic                              text_hit
);

  localparam int SEL_W  = $clog2(NUM_FIELDS + 1);
  localparam int CELL_W = GLYPH_W << SCALE_LOG2;
  localparam int CELL_H = GLYPH_H << SCALE_LOG2;

  localparam logic [11:0] Y_LO    = 12'(Y0);
  localparam logic [11:0] Y_HI    = 12'(Y0 + CELL_H);
  localparam logic [11:0] FIELD_W = 12'(2 * CELL_W);

  function automatic logic [11:0] field_x(input int k);
    return 12'(X0 + k * FIELD_PITCH);
  endfunction

  // ---------------------------------------------------------------------------
  // Frame-start snapshot: rendering only ever reads the shadow copy, so the
  // digits cannot change partway down the screen.
  // ---------------------------------------------------------------------------
  logic [8*NUM_FIELDS-1:0] shadow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= '0;
    end else if (pix_x == 10'd0 && pix_y == 10'd0) begin
      shadow <= timer_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink phase for the edit cursor.
  // ---------------------------------------------------------------------------
  logic blink_hide;

`ifdef VGA_DIGIT_OVERLAY_BLINK_EN
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  blink_vis;

  // The phase flips when the counter rolls over, giving a half-period of
  // 2^BLINK_LOG2 frames. The phase starts visible out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + BLINK_LOG2'(1);
      if (&frame_cnt) begin
        blink_vis <= ~blink_vis;
      end
    end
  end

  assign blink_hide = ~blink_vis;
`else
  assign blink_hide = 1'b0;

  logic unused_blink_inputs;
  assign unused_blink_inputs = ^{frame_tick, cursor_sel};
`endif

  // ---------------------------------------------------------------------------
  // Stage 1 (combinational part): cell decode. Fields are scanned from the
  // highest index down so that, where fields overlap, the lowest index is
  // the last to assign and therefore wins.
  // ---------------------------------------------------------------------------
  logic [11:0] px, py, dx, dy, dx_s, dy_s;
  logic [7:0]  fbyte;
  logic [3:0]  nibble;
  logic        hit_c, units_c, cursor_here, blank_c;
  logic [3:0]  code_c, row_c;
  logic [2:0]  col_c;
  logic        y_in;

  always_comb begin
    px          = {2'b00, pix_x};
    py          = {2'b00, pix_y};
    y_in        = (py >= Y_LO) && (py < Y_HI);
    dy          = py - Y_LO;
    hit_c       = 1'b0;
    dx          = '0;
    fbyte       = '0;
    cursor_here = 1'b0;

    for (int k = NUM_FIELDS - 1; k >= 0; k--) begin
      if (y_in && (px >= field_x(k)) && (px < field_x(k) + FIELD_W)) begin
        hit_c       = 1'b1;
        dx          = px - field_x(k);
        fbyte       = shadow[8*k +: 8];
        cursor_here = (cursor_sel == SEL_W'(k + 1));
      end
    end

    // Offsets in glyph units: bit 3 of the scaled x offset selects the
    // units digit, the low three bits are the glyph column.
    dx_s    = dx >> SCALE_LOG2;
    dy_s    = dy >> SCALE_LOG2;
    units_c = dx_s[3];
    col_c   = dx_s[2:0];
    row_c   = dy_s[3:0];
    nibble  = units_c ? fbyte[3:0] : fbyte[7:4];

    blank_c = !hit_c || (nibble > MAX_DIGIT) || (cursor_here && blink_hide);
    code_c  = blank_c ? BLANK_CODE : nibble;
  end

  // Only the low nibble of each scaled offset is meaningful inside a cell.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{dx_s[11:4], dy_s[11:4]};

  // ---------------------------------------------------------------------------
  // Stage 1 registers. The ROM registers its address on the same edge, so
  // code and row live inside the ROM's read register rather than here.
  // ---------------------------------------------------------------------------
  stage1_t    s1;
  logic       s1_en;
  logic [7:0] rom_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      s1_en <= 1'b0;
    end else begin
      s1.hit   <= hit_c;
      s1.blank <= blank_c;
      s1.col   <= col_c;
      s1_en    <= video_on & okmaquina;
    end
  end

  digit_font_rom u_font_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (rom_addr(code_c, row_c)),
    .data  (rom_data)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: pick the glyph bit and register the outputs.
  // ---------------------------------------------------------------------------
  logic pix_on;
  assign pix_on = s1_en && s1.hit && !s1.blank && rom_data[3'd7 - s1.col];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgbtext  <= RGB_BLACK;
      text_hit <= 1'b0;
    end else begin
      rgbtext  <= pix_on ? COLOR : RGB_BLACK;
      text_hit <= s1_en & s1.hit;
    end
  end

endmodule

// File: tb/tb_vga_digit_overlay.sv
// -----------------------------------------------------------------------------
// tb_vga_digit_overlay
//   Directed bench for vga_digit_overlay with default parameters. Expected
//   pixels are hand-derived from the 8x16 digit font; field k is byte k of
//   timer_in (field 0 = low byte), tens digit in the high nibble.
// -----------------------------------------------------------------------------
module tb_vga_digit_overlay;

  localparam logic [11:0] FG = 12'h0FF;

  logic        clk;
  logic        reset;
  logic        okmaquina;
  logic        video_on;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [23:0] timer_in;
  logic [1:0]  cursor_sel;
  logic        frame_tick;
  logic [11:0] rgbtext;
  logic        text_hit;

  int errors = 0;
  int checks = 0;

  vga_digit_overlay dut (
    .clk        (clk),
    .reset      (reset),
    .okmaquina  (okmaquina),
    .video_on   (video_on),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .timer_in   (timer_in),
    .cursor_sel (cursor_sel),
    .frame_tick (frame_tick),
    .rgbtext    (rgbtext),
    .text_hit   (text_hit)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_pix(input int x, input int y);
    @(negedge clk);
    pix_x = 10'(x);
    pix_y = 10'(y);
  endtask

  // Output for the pixel just driven is valid after two rising edges.
  task automatic wait_out();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  // Present pixel (0,0) for one clock so the shadow captures timer_in.
  task automatic snapshot(input logic [23:0] v);
    timer_in = v;
    drive_pix(0, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset      = 1'b0;
    okmaquina  = 1'b1;
    video_on   = 1'b1;
    frame_tick = 1'b0;
    cursor_sel = 2'd0;
    timer_in   = 24'h123456;
    pix_x      = 10'd200;
    pix_y      = 10'd330;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rgbtext !== 12'h000 || text_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rgb=%h hit=%b, want rgb=000 hit=0", rgbtext, text_hit);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hit;
    logic       on;
  } vec_t;

  task automatic test_glyph();
    vec_t v[13];
    logic [11:0] exp_rgb;
    // timer 123456: f0 = 5|6, f1 = 3|4, f2 = 1|2
    v[0]  = '{10'd200, 10'd330, 1'b1, 1'b1}; // f0 tens '5' r2 c2 (FE)
    v[1]  = '{10'd255, 10'd330, 1'b1, 1'b0}; // f0 units '6' r2 c7 (38), last inside col
    v[2]  = '{10'd256, 10'd330, 1'b0, 1'b0}; // first column past field 0
    v[3]  = '{10'd191, 10'd330, 1'b0, 1'b0}; // column before field 0
    v[4]  = '{10'd192, 10'd320, 1'b1, 1'b0}; // top-left, row 0 empty
    v[5]  = '{10'd200, 10'd383, 1'b1, 1'b0}; // last row, row 15 empty
    v[6]  = '{10'd200, 10'd384, 1'b0, 1'b0}; // below cells
    v[7]  = '{10'd200, 10'd319, 1'b0, 1'b0}; // above cells
    v[8]  = '{10'd344, 10'd340, 1'b1, 1'b1}; // f1 tens '3' r5 c6 (06)
    v[9]  = '{10'd480, 10'd352, 1'b1, 1'b0}; // f2 units '2' r8 c0 (60)
    v[10] = '{10'd484, 10'd352, 1'b1, 1'b1}; // f2 units '2' r8 c1
    v[11] = '{10'd383, 10'd330, 1'b1, 1'b0}; // f1 units '4' r2 c7 (0C)
    v[12] = '{10'd384, 10'd330, 1'b0, 1'b0}; // past field 1
    snapshot(24'h123456);
    for (int i = 0; i < 13; i++) begin
      drive_pix(int'(v[i].x), int'(v[i].y));
      wait_out();
      exp_rgb = v[i].on ? FG : 12'h000;
      checks++;
      if (rgbtext !== exp_rgb || text_hit !== v[i].hit) begin
        errors++;
        $display("FAIL glyph_vec%0d (%0d,%0d): rgb=%h hit=%b, want rgb=%h hit=%b",
                 i, v[i].x, v[i].y, rgbtext, text_hit, exp_rgb, v[i].hit);
      end
    end
  endtask

  task automatic test_snapshot();
    snapshot(24'h000000);
    drive_pix(208, 340);                      // '0' r5 c4 set, '9' r5 c4 clear
    wait_out();
    checks++;
    if (rgbtext !== FG) begin
      errors++;
      $display("FAIL snap_zero: rgb=%h, want %h", rgbtext, FG);
    end
    timer_in = 24'h999999;                    // mid-frame change
    drive_pix(208, 340);
    wait_out();
    checks++;
    if (rgbtext !== FG) begin
      errors++;
      $display("FAIL snap_no_tear_a: rgb=%h, want %h", rgbtext, FG);
    end
    drive_pix(200, 344);                      // '0' r6 c2 clear, '9' r6 c2 set
    wait_out();
    checks++;
    if (rgbtext !== 12'h000) begin
      errors++;
      $display("FAIL snap_no_tear_b: rgb=%h, want 000", rgbtext);
    end
    snapshot(24'h999999);                     // next frame start
    drive_pix(208, 340);
    wait_out();
    checks++;
    if (rgbtext !== 12'h000) begin
      errors++;
      $display("FAIL snap_nine_a: rgb=%h, want 000", rgbtext);
    end
    drive_pix(200, 344);
    wait_out();
    checks++;
    if (rgbtext !== FG) begin
      errors++;
      $display("FAIL snap_nine_b: rgb=%h, want %h", rgbtext, FG);
    end
  endtask

  task automatic test_invalid_nibble();
    snapshot(24'h12A456);                     // field 1 tens = A
    for (int y = 320; y < 384; y += 4) begin
      for (int x = 320; x < 352; x += 2) begin
        drive_pix(x, y);
        wait_out();
        checks++;
        if (rgbtext !== 12'h000 || text_hit !== 1'b1) begin
          errors++;
          $display("FAIL bad_nibble (%0d,%0d): rgb=%h hit=%b, want rgb=000 hit=1",
                   x, y, rgbtext, text_hit);
        end
      end
    end
    drive_pix(352, 348);                      // field 1 units '4' r7 c0 (FE)
    wait_out();
    checks++;
    if (rgbtext !== FG || text_hit !== 1'b1) begin
      errors++;
      $display("FAIL bad_nibble_units: rgb=%h hit=%b, want rgb=%h hit=1", rgbtext, text_hit, FG);
    end
  endtask

  task automatic test_gating();
    snapshot(24'h123456);
    drive_pix(200, 330);
    wait_out();
    checks++;
    if (rgbtext !== FG) begin
      errors++;
      $display("FAIL gate_pre: rgb=%h, want %h", rgbtext, FG);
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      if (g == 0) video_on = 1'b0;
      else        okmaquina = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rgbtext !== FG || text_hit !== 1'b1) begin
        errors++;
        $display("FAIL gate%0d_one_clk: rgb=%h hit=%b, want rgb=%h hit=1", g, rgbtext, text_hit, FG);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rgbtext !== 12'h000 || text_hit !== 1'b0) begin
        errors++;
        $display("FAIL gate%0d_two_clk: rgb=%h hit=%b, want rgb=000 hit=0", g, rgbtext, text_hit);
      end
      @(negedge clk);
      video_on  = 1'b1;
      okmaquina = 1'b1;
      wait_out();
      checks++;
      if (rgbtext !== FG) begin
        errors++;
        $display("FAIL gate%0d_restore: rgb=%h, want %h", g, rgbtext, FG);
      end
    end
  endtask

  task automatic test_blink();
    logic vis;
    logic [11:0] exp_rgb;
    cursor_sel = 2'd2;                        // field 1 is the cursor
    for (int i = 0; i <= 40; i++) begin
      if (i > 0) begin
        if (i == 40) timer_in = 24'h000000;   // snapshot in the same cycle as a tick
        @(negedge clk);
        pix_x      = 10'd0;
        pix_y      = 10'd0;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
      end
`ifdef VGA_DIGIT_OVERLAY_BLINK_EN
      vis = (((i / 16) % 2) == 0);
`else
      vis = 1'b1;
`endif
      exp_rgb = vis ? FG : 12'h000;
      drive_pix(344, 340);                    // f1 tens: '3' r5 c6, or '0' r5 c6 at i=40
      wait_out();
      checks++;
      if (rgbtext !== exp_rgb || text_hit !== 1'b1) begin
        errors++;
        $display("FAIL blink_f1 tick%0d: rgb=%h hit=%b, want rgb=%h hit=1",
                 i, rgbtext, text_hit, exp_rgb);
      end
      drive_pix(200, 330);                    // f0 tens never blinks
      wait_out();
      checks++;
      if (rgbtext !== FG) begin
        errors++;
        $display("FAIL blink_f0 tick%0d: rgb=%h, want %h", i, rgbtext, FG);
      end
    end
    drive_pix(200, 344);                      // '0' r6 c2 clear ('5' would be set)
    wait_out();
    checks++;
    if (rgbtext !== 12'h000 || text_hit !== 1'b1) begin
      errors++;
      $display("FAIL tick_with_snapshot: rgb=%h hit=%b, want rgb=000 hit=1", rgbtext, text_hit);
    end
  endtask

  task automatic test_reset_midline();
    cursor_sel = 2'd1;
    drive_pix(200, 330);                      // shadow 0: '0' r2 c2 set
    wait_out();
    checks++;
    if (rgbtext !== FG) begin
      errors++;
      $display("FAIL rst_pre: rgb=%h, want %h", rgbtext, FG);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rgbtext !== 12'h000 || text_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: rgb=%h hit=%b, want rgb=000 hit=0", rgbtext, text_hit);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rgbtext !== 12'h000 || text_hit !== 1'b0) begin
      errors++;
      $display("FAIL rst_early: rgb=%h hit=%b, want rgb=000 hit=0", rgbtext, text_hit);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rgbtext !== FG || text_hit !== 1'b1) begin
      errors++;
      $display("FAIL rst_first_pixel: rgb=%h hit=%b, want rgb=%h hit=1", rgbtext, text_hit, FG);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_glyph();
    test_snapshot();
    test_invalid_nibble();
    test_gating();
    test_blink();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
